// File: rtl/des_pkg.sv
// Shared types and default parameters for the serial deserializer with sync-word alignment.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package des_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } des_state_t;

    localparam int          DES_W         = 8;
    localparam logic [7:0]  DES_SYNC_WORD = 8'hBC;
    localparam int          DES_LOCK_CNT  = 3;
    localparam int          DES_DEPTH     = 4;

endpackage

// File: rtl/des_sync_fifo.sv
// Generic show-ahead synchronous FIFO with flush; the head word is visible on rdata whenever not empty.
// Latency: a word written at edge N is on rdata from edge N onward.
// Backpressure: a push when full is accepted only together with a pop; otherwise the caller must hold off.
module des_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // Full plus a simultaneous pop frees the slot being written this edge.
    assign do_push = push && (!full || do_pop);

    // Gated so the output reads zero rather than stale storage while empty.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/des_align_fifo.sv
// Serial deserializer: hunts for SYNC_WORD at any bit offset, locks after LOCK_CNT aligned syncs, queues data words.
// Latency: a word is on out_data the cycle after its last bit is sampled.
// Backpressure: out_valid/out_ready; words arriving while the FIFO is full and not popping are dropped and flag overflow.
module des_align_fifo
    import des_pkg::*;
#(
    parameter int           W         = DES_W,
    parameter logic [W-1:0] SYNC_WORD = W'(DES_SYNC_WORD),
    parameter int           LOCK_CNT  = DES_LOCK_CNT,
    parameter int           DEPTH     = DES_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_data,
    input  logic                     in_en,
    input  logic                     resync,
    output logic [W-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     locked,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int BW = (W > 2) ? $clog2(W) : 1;
    localparam int HW = $clog2(LOCK_CNT + 1);

    des_state_t     state, state_nxt;
    logic [W-1:0]   sr, sr_nxt;
    logic [BW-1:0]  bitcnt, bitcnt_nxt;
    logic [HW-1:0]  hits, hits_nxt;
    logic [HW-1:0]  hits_inc;
    logic           boundary;
    logic           is_sync;
    logic           push_req;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;

    assign hits_inc  = hits + 1'b1;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_comb begin
        sr_nxt     = in_en ? {sr[W-2:0], in_data} : sr;
        boundary   = in_en && (bitcnt == BW'(W - 1));
        is_sync    = (sr_nxt == SYNC_WORD);
        state_nxt  = state;
        hits_nxt   = hits;
        push_req   = 1'b0;
        bitcnt_nxt = bitcnt;
        if (in_en) bitcnt_nxt = boundary ? '0 : bitcnt + 1'b1;

        unique case (state)
            HUNT: begin
                // Every sampled bit is a candidate alignment point.
                if (in_en && is_sync) begin
                    bitcnt_nxt = '0;
                    hits_nxt   = HW'(1);
                    state_nxt  = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (is_sync) begin
                        hits_nxt = hits_inc;
                        if (hits_inc == HW'(LOCK_CNT)) state_nxt = LOCKED;
                    end else begin
                        hits_nxt  = '0;
                        state_nxt = HUNT;
                    end
                end
            end
            LOCKED: begin
                // Sync words in the data stream are keep-alives, never payload.
                if (boundary && !is_sync) push_req = 1'b1;
            end
            default: state_nxt = HUNT;
        endcase

        if (resync) begin
            sr_nxt     = '0;
            bitcnt_nxt = '0;
            hits_nxt   = '0;
            state_nxt  = HUNT;
            push_req   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            sr       <= '0;
            bitcnt   <= '0;
            hits     <= '0;
            locked   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            bitcnt   <= bitcnt_nxt;
            hits     <= hits_nxt;
            locked   <= (state_nxt == LOCKED);
            if (resync)
                overflow <= 1'b0;
            else if (push_req && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    des_sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (resync),
        .push  (push_req),
        .wdata (sr_nxt),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_des_align_fifo.sv
// Directed bench for des_align_fifo with a queue scoreboard of expected output words.
// Latency: n/a. Backpressure: out_ready driven by the directed steps.
module tb_des_align_fifo;
    import des_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_data = 1'b0;
    logic       in_en = 1'b0;
    logic       resync = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       locked;
    logic       overflow;
    logic [2:0] level;

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_pop = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_word;

    always #5 clk = ~clk;

    des_align_fifo #(
        .W(8), .SYNC_WORD(8'hBC), .LOCK_CNT(3), .DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_en     (in_en),
        .resync    (resync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .locked    (locked),
        .overflow  (overflow),
        .level     (level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted output word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_pop++;
            n_chk++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL pop_unexpected: observed %0h expected none", out_data);
            end
            if (sb.size() != 0) begin
                exp_word = sb.pop_front();
                n_chk++;
                assert (out_data === exp_word) else begin
                    n_fail++;
                    $error("FAIL pop_data: observed %0h expected %0h", out_data, exp_word);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        in_en   = 1'b1;
        in_data = b;
        tick();
        in_en   = 1'b0;
        in_data = 1'($urandom);
    endtask

    task automatic send_word(input logic [7:0] w, input bit expect_out);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        if (expect_out) sb.push_back(w);
    endtask

    task automatic send_word_gappy(input logic [7:0] w, input bit expect_out);
        for (int i = 7; i >= 0; i--) begin
            repeat ($urandom_range(0, 2)) begin
                in_en   = 1'b0;
                in_data = 1'($urandom);
                tick();
            end
            send_bit(w[i]);
        end
        if (expect_out) sb.push_back(w);
    endtask

    task automatic do_resync();
        resync = 1'b1;
        tick();
        resync = 1'b0;
    endtask

    initial begin
        logic [7:0] w;

        // Reset held with random serial activity
        for (int i = 0; i < 6; i++) begin
            in_en   = 1'($urandom);
            in_data = 1'($urandom);
            tick();
        end
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_locked",    32'(locked),    32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        in_en   = 1'b1;
        in_data = 1'($urandom);
        rst_n   = 1'b1;
        #1;
        chk("rst_release_state", 32'(dut.state), 32'(HUNT));
        in_en = 1'b0;
        tick();
        do_resync();

        // Lock at bit offset 3
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(8'hBC, 1'b0);
        send_word(8'hBC, 1'b0);
        w = 8'hBC;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        chk("lock_before_last_bit", 32'(locked), 32'd0);
        send_bit(w[0]);
        chk("lock_after_24th_bit", 32'(locked), 32'd1);
        send_word(8'hA5, 1'b1);
        chk("a5_out_valid", 32'(out_valid), 32'd1);
        chk("a5_out_data",  32'(out_data),  32'hA5);
        chk("a5_level_no_sync", 32'(level), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("a5_drained_valid", 32'(out_valid), 32'd0);
        chk("a5_pop_count", 32'(n_pop), 32'd1);

        // Failed verify then relock
        do_resync();
        chk("resync_unlocks", 32'(locked), 32'd0);
        send_word(8'hBC, 1'b0);
        send_word(8'hBC, 1'b0);
        send_word(8'h3C, 1'b0);
        chk("fv_locked", 32'(locked), 32'd0);
        chk("fv_state",  32'(dut.state), 32'(HUNT));
        send_word(8'hBC, 1'b0);
        send_word(8'hBC, 1'b0);
        send_word(8'hBC, 1'b0);
        chk("fv_relock", 32'(locked), 32'd1);

        // Overflow: fifth word dropped
        for (int v = 1; v <= 5; v++) send_word(8'(v), v <= 4);
        chk("ovf_level",    32'(level),    32'd4);
        chk("ovf_flag",     32'(overflow), 32'd1);
        chk("ovf_head",     32'(out_data), 32'h01);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ovf_drain_level", 32'(level), 32'(3 - i));
        end
        chk("ovf_drained_valid", 32'(out_valid), 32'd0);
        chk("ovf_sb_empty", 32'(sb.size()), 32'd0);
        chk("ovf_pop_count", 32'(n_pop), 32'd5);

        // Keep-alive sync between data words, gappy in_en
        send_word_gappy(8'h11, 1'b1);
        send_word_gappy(8'hBC, 1'b0);
        send_word_gappy(8'h22, 1'b1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        tick();
        chk("ka_sb_empty",  32'(sb.size()), 32'd0);
        chk("ka_pop_count", 32'(n_pop), 32'd7);
        chk("ka_level",     32'(level), 32'd0);
        chk("ka_locked",    32'(locked), 32'd1);
        out_ready = 1'b0;

        // Resync mid-word with a full FIFO and overflow set
        for (int v = 1; v <= 5; v++) send_word(8'(8'h40 + v), v <= 4);
        chk("rs_pre_overflow", 32'(overflow), 32'd1);
        chk("rs_pre_level",    32'(level),    32'd4);
        w = 8'h66;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        in_en   = 1'b1;
        in_data = w[0];
        resync  = 1'b1;
        tick();
        resync  = 1'b0;
        in_en   = 1'b0;
        chk("rs_locked",    32'(locked),    32'd0);
        chk("rs_level",     32'(level),     32'd0);
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_overflow",  32'(overflow),  32'd0);
        sb.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        chk("rs_no_partial_valid", 32'(out_valid), 32'd0);
        chk("rs_no_partial_pops",  32'(n_pop), 32'd7);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/des_align_fifo.md
# des_align_fifo

Parametrised successor to the fixed 8-bit deserializer. It shifts in a gated serial bit stream and hunts for a programmable sync word at any bit offset. After a configurable number of consecutive aligned sync words it declares lock, then forwards non-sync words into an internal show-ahead FIFO with a ready/valid output. It sits between the serial receive front end and the parallel datapath, and replaces the fixed-offset 8-bit capture.

## Interface
- `W`, 8: word width; must be at least 2.
- `SYNC_WORD`, `'hBC` (W bits): alignment pattern.
- `LOCK_CNT`, 3: number of consecutive aligned sync words needed to lock; must be at least 1.
- `DEPTH`, 4: FIFO entries; a power of 2, at least 2.
- `clk` in 1: the single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 1: serial bit, MSB first.
- `in_en` in 1: `in_data` is valid this cycle; gaps are allowed.
- `resync` in 1: synchronous force-to-HUNT plus flush.
- `out_data` out W: FIFO head word.
- `out_valid` out 1: FIFO is non-empty.
- `out_ready` in 1: consumer accepts the head word.
- `locked` out 1: state is LOCKED.
- `overflow` out 1: sticky; a word was dropped because the FIFO was full.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Shift register `sr` is W bits. On `in_en`, `sr_next = {sr[W-2:0], in_data}`; otherwise `sr` holds.
- `bitcnt` counts 0..W-1 and advances only on `in_en`. A boundary occurs when `in_en && bitcnt==W-1`; the completed word is `sr_next`.
- HUNT: `sr_next` is compared every `in_en` cycle. On a match, `bitcnt` goes to 0 and `hits` goes to 1. The next state is LOCKED if `LOCK_CNT==1`, otherwise VERIFY.
- VERIFY: at each boundary, a word equal to SYNC increments `hits`. When `hits` reaches `LOCK_CNT` the state goes to LOCKED. Any other word sends the state to HUNT with `hits` cleared. Words are never pushed into the FIFO in HUNT or VERIFY.
- LOCKED: at each boundary, a SYNC word is discarded (it acts as a keep-alive) and any other word is pushed. LOCKED is left only by `resync` or by reset.
- Push while full:
  - With a simultaneous pop, the push succeeds.
  - Without a pop, the word is dropped and `overflow` is set to 1.
- Pop happens on `out_valid && out_ready`.
- `resync` has highest priority:
  - state goes to HUNT;
  - `bitcnt`, `hits` and `sr` are cleared;
  - the FIFO is flushed;
  - `overflow` is cleared;
  - any word completing in the same cycle is dropped.
- Reset values: `sr`=0, `bitcnt`=0, `hits`=0, state HUNT; `out_valid`=0, `locked`=0, `overflow`=0, `level`=0, `out_data`=0.

## Timing
- Push latency: the last bit of a word is sampled at edge N and the word is written at edge N. `out_valid` and `out_data` are valid from edge N onward, i.e. the cycle after the final bit's `in_en` cycle.
- `locked` is registered from the state. It rises at the edge where the `LOCK_CNT`-th sync completes and falls at the edge where `resync` is sampled.
- Throughput: one pop per cycle while `out_ready` is held high.
- Pushes occur at most once every W `in_en` cycles.
- `level` updates at the same edge as the push or pop; a simultaneous push and pop leaves it unchanged.
- `out_data` is stable while `out_valid` is high and `out_ready` is low.
- Asserting `rst_n` low mid-word clears all state immediately. There is no partial-word recovery.

## Structure
- Package `des_pkg` holds:
  - typedef enum `des_state_t` {HUNT, VERIFY, LOCKED};
  - default localparams for W, SYNC_WORD, LOCK_CNT and DEPTH.
- Sub-module `des_sync_fifo` with parameters W and DEPTH:
  - ports: `clk`, `rst_n`, `flush`, `push`/`wdata`, `pop`/`rdata`, `full`, `empty`, `level`;
  - show-ahead read; pointers one bit wider than the address.
- The top level contains the shifter, bit counter, alignment FSM and overflow flag.

## Test plan
All scenarios use W=8, SYNC='hBC, LOCK_CNT=3, DEPTH=4.
- Reset: hold `rst_n`=0 with random `in_data`/`in_en` -> `out_valid`=0, `locked`=0, `overflow`=0, `level`=0; `rst_n` released mid-stream -> state HUNT.
- Lock at offset 3: bits 101, then BC BC BC, then A5 -> `locked`=1 after the 24th sync bit; `out_data`=A5 with `out_valid`=1 the cycle after its 8th bit; no BC appears in the FIFO.
- Failed verify: BC BC 3C -> `locked` stays 0 and the state returns to HUNT; a following BC BC BC -> locks.
- Overflow: locked, `out_ready`=0, send 01 02 03 04 05 -> `level`=4, `overflow`=1, 05 lost; then `out_ready`=1 -> 01 02 03 04 on consecutive cycles, then `out_valid`=0.
- Keep-alive plus gaps: locked, send 11 BC 22 with random `in_en` gaps -> FIFO outputs exactly 11 then 22.
- Resync mid-word with full FIFO and `overflow`=1 -> next cycle `locked`=0, `level`=0, `out_valid`=0, `overflow`=0; a partial word is never output.
